busy_table_ckpt: RTL and testbench
==================================

Name: busy_table_ckpt

Overview:
Parametrised next-generation physical-register busy table for the rename stage.
- Sets a busy bit when a PRN leaves the free list; clears it on execution writeback.
- Answers per-slot source readiness, including intra-group and same-cycle writeback forwarding.
- Adds branch checkpoints: snapshots of the table are kept up to date by writebacks and restored on mispredict, so only a full `pipe_flush` clears the whole table.

Parameters:
- MACHINE_WIDTH, 4, rename slots per cycle (slot 0 oldest).
- ISSUE_WIDTH, 7, writeback ports.
- PRF_DEPTH, 64, physical registers.
- PRF_WIDTH, 6, PRN width; equals clog2(PRF_DEPTH).
- NUM_CKPT, 4, checkpoint slots.
- CKPT_WIDTH, 2, checkpoint id width; equals clog2(NUM_CKPT).
- ZERO_PRN_READY, 1, when 1, PRN 0 is never busy and always reports ready.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pipe_flush  in  1  clear table and all checkpoints.
- alloc_prn  in  MACHINE_WIDTH*PRF_WIDTH  allocated PRN per slot; slot i at [i*PRF_WIDTH +: PRF_WIDTH].
- alloc_valid  in  MACHINE_WIDTH  slot has an allocation.
- alloc_ready  in  MACHINE_WIDTH  free list accepts; alloc_fire[i] = alloc_valid[i] & alloc_ready[i].
- wb_prn  in  ISSUE_WIDTH*PRF_WIDTH  writeback destination PRNs.
- wb_valid  in  ISSUE_WIDTH  writeback valid.
- src1_prn, src2_prn  in  MACHINE_WIDTH*PRF_WIDTH  source PRNs per slot.
- src1_ready, src2_ready  out  MACHINE_WIDTH  source data ready.
- ckpt_save  in  1  take a snapshot this cycle.
- ckpt_save_id  in  CKPT_WIDTH  destination checkpoint.
- ckpt_save_slot  in  CLOG2(MACHINE_WIDTH)  branch slot; allocations in slots 0..ckpt_save_slot are included in the snapshot.
- ckpt_restore  in  1  mispredict recovery.
- ckpt_restore_id  in  CKPT_WIDTH  checkpoint to restore.
- busy_count  out  PRF_WIDTH+1  registered population count of the live table.

Behaviour:
Reset and flush
- rst_n low clears the table, all checkpoints and busy_count to 0, asynchronously.
- pipe_flush has the same effect synchronously and has priority over everything else.

Live-table update (one cycle; result visible the next cycle)
- For each PRN p: next = (busy[p] | any alloc_fire[i] with alloc_prn[i]==p) & ~(any wb_valid[j] with wb_prn[j]==p).
- Writeback clear beats allocation set for the same PRN in the same cycle.
- With ZERO_PRN_READY=1, bit 0 is held at 0.

Lookup (combinational; slot k, source s)
- ready = (~busy[s] | any wb_valid[j] with wb_prn[j]==s) & ~(any alloc_fire[i], i<k, with alloc_prn[i]==s).
- Slot 0 has no intra-group term.
- With ZERO_PRN_READY=1, s==0 forces ready=1.
- Intra-group allocation overrides writeback forwarding.

Checkpoint save
- ckpt[save_id] <= (busy | allocs from slots 0..save_slot) & ~(all wb this cycle).
- Allocations in slots above save_slot are excluded.
- Saving to an id that is already used overwrites it.

Writeback tracking
- Every cycle, every checkpoint clears the bits of all valid wb_prn.
- This makes a later restore never re-busy a completed register.

Restore
- busy <= ckpt[restore_id] & ~(all wb this cycle).
- Same-cycle allocations are ignored.
- The restored checkpoint itself is retained; it is also updated by that cycle's writebacks.

Simultaneous events
- Restore together with save: restore wins and the save is dropped.
- Restore together with a lookup: lookup outputs are still computed from the pre-restore table; the rename stage discards them.
- Duplicate PRNs across alloc slots, or the same PRN on two wb ports: idempotent.

busy_count
- Registered; equals the number of set bits in the live table after each update.
- Maximum value PRF_DEPTH.

Test Plan:
1. Reset, then alloc slot0 PRN 5 with alloc_ready=0 -> busy_count stays 0; src1_prn slot1=5 reads ready.
2. Alloc slots 0..3 = PRN 10,11,12,13; src1 of slot 3 = 10, src2 of slot 2 = 13 -> src1_ready[3]=0, src2_ready[2]=1. Next cycle busy_count=4; src reads of 10..13 return 0.
3. PRN 20 busy; wb_valid[6] with wb_prn=20 in the same cycle as a lookup of 20 -> ready=1 that cycle; busy[20]=0 next cycle. Alloc and wb of PRN 21 in the same cycle -> busy[21]=0.
4. Alloc PRN 30,31,32 in slots 0..2 with ckpt_save id 1, save_slot 1. Next cycle alloc PRN 40. Then restore id 1 -> PRN 30,31 busy; PRN 32,40 not busy; busy_count=2.
5. Save ckpt 2 with PRN 50 busy; later wb PRN 50; then restore 2 -> PRN 50 ready. Restore together with save to id 3 -> ckpt 3 unchanged.
6. ZERO_PRN_READY=1: alloc PRN 0 -> src read of 0 is ready, busy_count unchanged. pipe_flush with busy_count=7 -> busy_count 0 next cycle, and all checkpoints restore to empty.

Source files
------------

// File: rtl/busy_table_ckpt.sv
// Physical-register busy table for rename, with branch checkpoints that track
// writebacks so a mispredict restore never re-busies a completed register.
module busy_table_ckpt #(
   parameter int MACHINE_WIDTH  = 4,
   parameter int ISSUE_WIDTH    = 7,
   parameter int PRF_DEPTH      = 64,
   parameter int PRF_WIDTH      = 6,
   parameter int NUM_CKPT       = 4,
   parameter int CKPT_WIDTH     = 2,
   parameter int ZERO_PRN_READY = 1,
   localparam int SLOT_W        = (MACHINE_WIDTH > 1) ? $clog2(MACHINE_WIDTH) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               pipe_flush,
   input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] alloc_prn,
   input  logic [MACHINE_WIDTH-1:0]           alloc_valid,
   input  logic [MACHINE_WIDTH-1:0]           alloc_ready,
   input  logic [ISSUE_WIDTH*PRF_WIDTH-1:0]   wb_prn,
   input  logic [ISSUE_WIDTH-1:0]             wb_valid,
   input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] src1_prn,
   input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] src2_prn,
   output logic [MACHINE_WIDTH-1:0]           src1_ready,
   output logic [MACHINE_WIDTH-1:0]           src2_ready,
   input  logic                               ckpt_save,
   input  logic [CKPT_WIDTH-1:0]              ckpt_save_id,
   input  logic [SLOT_W-1:0]                  ckpt_save_slot,
   input  logic                               ckpt_restore,
   input  logic [CKPT_WIDTH-1:0]              ckpt_restore_id,
   output logic [PRF_WIDTH:0]                 busy_count
);

   // PRN 0 is pinned idle when it models an architectural zero register
   localparam logic [PRF_DEPTH-1:0] KEEP_MASK = (ZERO_PRN_READY != 0) ?
      {{(PRF_DEPTH-1){1'b1}}, 1'b0} : {PRF_DEPTH{1'b1}};

   logic [PRF_DEPTH-1:0]     busy_q, busy_d;
   logic [PRF_DEPTH-1:0]     ckpt_q [NUM_CKPT];
   logic [PRF_DEPTH-1:0]     ckpt_d [NUM_CKPT];
   logic [PRF_WIDTH:0]       busy_count_q, busy_count_d;
   logic [MACHINE_WIDTH-1:0] alloc_fire_s;
   logic [PRF_DEPTH-1:0]     alloc_all_s, alloc_ckpt_s, wb_mask_s, snap_s;

   function automatic logic [PRF_WIDTH:0] popcount(input logic [PRF_DEPTH-1:0] v);
      logic [PRF_WIDTH:0] cnt;
      cnt = {(PRF_WIDTH+1){1'b0}};
      for (int i = 0; i < PRF_DEPTH; i++) begin
         cnt = cnt + {{PRF_WIDTH{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // Older slots in the group that allocate the same PRN override writeback forwarding
   function automatic logic src_ready(
      input logic [PRF_DEPTH-1:0]           busy,
      input logic [PRF_DEPTH-1:0]           wb_mask,
      input logic [MACHINE_WIDTH-1:0]       fire,
      input logic [MACHINE_WIDTH*PRF_WIDTH-1:0] prns,
      input logic [PRF_WIDTH-1:0]           src,
      input int                             slot
   );
      logic rdy;
      rdy = ~busy[src] | wb_mask[src];
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         rdy = ((i < slot) && fire[i] && (prns[i*PRF_WIDTH +: PRF_WIDTH] == src)) ? 1'b0 : rdy;
      end
      rdy = ((ZERO_PRN_READY != 0) && (src == {PRF_WIDTH{1'b0}})) ? 1'b1 : rdy;
      return rdy;
   endfunction

   // Decode allocation and writeback ports into per-PRN masks
   always_comb begin
      alloc_fire_s = alloc_valid & alloc_ready;
      alloc_all_s  = {PRF_DEPTH{1'b0}};
      alloc_ckpt_s = {PRF_DEPTH{1'b0}};
      wb_mask_s    = {PRF_DEPTH{1'b0}};
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         alloc_all_s[alloc_prn[i*PRF_WIDTH +: PRF_WIDTH]] =
            alloc_all_s[alloc_prn[i*PRF_WIDTH +: PRF_WIDTH]] | alloc_fire_s[i];
         alloc_ckpt_s[alloc_prn[i*PRF_WIDTH +: PRF_WIDTH]] =
            alloc_ckpt_s[alloc_prn[i*PRF_WIDTH +: PRF_WIDTH]] |
            (alloc_fire_s[i] & (i <= int'(ckpt_save_slot)));
      end
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
         wb_mask_s[wb_prn[j*PRF_WIDTH +: PRF_WIDTH]] =
            wb_mask_s[wb_prn[j*PRF_WIDTH +: PRF_WIDTH]] | wb_valid[j];
      end
   end

   // Source readiness lookup, always from the pre-update table
   always_comb begin
      src1_ready = {MACHINE_WIDTH{1'b0}};
      src2_ready = {MACHINE_WIDTH{1'b0}};
      for (int k = 0; k < MACHINE_WIDTH; k++) begin
         src1_ready[k] = src_ready(busy_q, wb_mask_s, alloc_fire_s, alloc_prn,
                                   src1_prn[k*PRF_WIDTH +: PRF_WIDTH], k);
         src2_ready[k] = src_ready(busy_q, wb_mask_s, alloc_fire_s, alloc_prn,
                                   src2_prn[k*PRF_WIDTH +: PRF_WIDTH], k);
      end
   end

   // Next live table and checkpoints; restore drops any same-cycle save
   always_comb begin
      snap_s = (busy_q | alloc_ckpt_s) & ~wb_mask_s & KEEP_MASK;
      busy_d = busy_q;
      for (int c = 0; c < NUM_CKPT; c++) begin
         ckpt_d[c] = ckpt_q[c];
      end
      if (pipe_flush) begin
         busy_d = {PRF_DEPTH{1'b0}};
         for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_d[c] = {PRF_DEPTH{1'b0}};
         end
      end else if (ckpt_restore) begin
         busy_d = ckpt_q[ckpt_restore_id] & ~wb_mask_s & KEEP_MASK;
         for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_d[c] = ckpt_q[c] & ~wb_mask_s & KEEP_MASK;
         end
      end else begin
         busy_d = (busy_q | alloc_all_s) & ~wb_mask_s & KEEP_MASK;
         for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_d[c] = (ckpt_save && (ckpt_save_id == CKPT_WIDTH'(c))) ?
                        snap_s : (ckpt_q[c] & ~wb_mask_s & KEEP_MASK);
         end
      end
      busy_count_d = popcount(busy_d);
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= {PRF_DEPTH{1'b0}};
         busy_count_q <= {(PRF_WIDTH+1){1'b0}};
         for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_q[c] <= {PRF_DEPTH{1'b0}};
         end
      end else begin
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
         for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_q[c] <= ckpt_d[c];
         end
      end
   end

   assign busy_count = busy_count_q;

endmodule

// File: tb/tb_busy_table_ckpt.sv
// Scoreboard bench for busy_table_ckpt: directed scenarios plus a random phase
// checked against a behavioural model of the table and its checkpoints.
module tb_busy_table_ckpt;
   localparam int MW = 4, IW = 7, PW = 6, PD = 64, NC = 4, CW = 2;
   localparam int SEL_R1 = 0, SEL_R2 = 1, SEL_CNT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, pipe_flush;
   logic [MW*PW-1:0]  alloc_prn, src1_prn, src2_prn;
   logic [MW-1:0]     alloc_valid, alloc_ready, src1_ready, src2_ready;
   logic [IW*PW-1:0]  wb_prn;
   logic [IW-1:0]     wb_valid;
   logic              ckpt_save, ckpt_restore;
   logic [CW-1:0]     ckpt_save_id, ckpt_restore_id;
   logic [1:0]        ckpt_save_slot;
   logic [PW:0]       busy_count;

   busy_table_ckpt dut (
      .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
      .alloc_prn(alloc_prn), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .wb_prn(wb_prn), .wb_valid(wb_valid),
      .src1_prn(src1_prn), .src2_prn(src2_prn),
      .src1_ready(src1_ready), .src2_ready(src2_ready),
      .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id), .ckpt_save_slot(ckpt_save_slot),
      .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
      .busy_count(busy_count)
   );

   typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
   exp_t sbq[$];
   int n_tests = 0, n_fail = 0;

   logic [PD-1:0] m_busy;
   logic [PD-1:0] m_ck [NC];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.sel = sel; e.exp = exp;
      sbq.push_back(e);
   endtask

   function automatic int popc(input logic [PD-1:0] v);
      int n = 0;
      for (int i = 0; i < PD; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic clear_inputs();
      pipe_flush = 1'b0; alloc_prn = '0; alloc_valid = '0; alloc_ready = '0;
      wb_prn = '0; wb_valid = '0; src1_prn = '0; src2_prn = '0;
      ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_save_slot = '0;
      ckpt_restore = 1'b0; ckpt_restore_id = '0;
   endtask

   task automatic alloc(input int slot, input int prn);
      alloc_prn[slot*PW +: PW] = PW'(prn);
      alloc_valid[slot] = 1'b1;
      alloc_ready[slot] = 1'b1;
   endtask

   task automatic wb(input int port, input int prn);
      wb_prn[port*PW +: PW] = PW'(prn);
      wb_valid[port] = 1'b1;
   endtask

   function automatic logic [PD-1:0] wb_bits();
      logic [PD-1:0] m = '0;
      for (int j = 0; j < IW; j++) if (wb_valid[j]) m[wb_prn[j*PW +: PW]] = 1'b1;
      return m;
   endfunction

   function automatic logic exp_ready(input logic [PW-1:0] s, input int k);
      logic r;
      if (s == 0) return 1'b1;
      r = !m_busy[s] || wb_bits()[s];
      for (int i = 0; i < k; i++)
         if (alloc_valid[i] && alloc_ready[i] && alloc_prn[i*PW +: PW] == s) r = 1'b0;
      return r;
   endfunction

   task automatic model_update();
      logic [PD-1:0] wbm, all_a, old_a, nb;
      wbm = wb_bits(); all_a = '0; old_a = '0;
      for (int i = 0; i < MW; i++) begin
         if (alloc_valid[i] && alloc_ready[i]) begin
            all_a[alloc_prn[i*PW +: PW]] = 1'b1;
            if (i <= int'(ckpt_save_slot)) old_a[alloc_prn[i*PW +: PW]] = 1'b1;
         end
      end
      if (pipe_flush) begin
         m_busy = '0;
         for (int c = 0; c < NC; c++) m_ck[c] = '0;
      end else begin
         if (ckpt_restore) nb = m_ck[ckpt_restore_id] & ~wbm;
         else              nb = (m_busy | all_a) & ~wbm;
         for (int c = 0; c < NC; c++) m_ck[c] = m_ck[c] & ~wbm;
         if (ckpt_save && !ckpt_restore) m_ck[ckpt_save_id] = (m_busy | old_a) & ~wbm;
         m_busy = nb;
      end
      m_busy[0] = 1'b0;
      for (int c = 0; c < NC; c++) m_ck[c][0] = 1'b0;
   endtask

   task automatic run_cycle(input string tag);
      logic [MW-1:0] e1, e2;
      exp_t e;
      logic [31:0] obs;
      for (int k = 0; k < MW; k++) begin
         e1[k] = exp_ready(src1_prn[k*PW +: PW], k);
         e2[k] = exp_ready(src2_prn[k*PW +: PW], k);
      end
      push({tag, "_m_r1"}, SEL_R1, 32'(e1));
      push({tag, "_m_r2"}, SEL_R2, 32'(e2));
      push({tag, "_m_cnt"}, SEL_CNT, 32'(popc(m_busy)));
      @(negedge clk);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.sel)
            SEL_R1:  obs = 32'(src1_ready);
            SEL_R2:  obs = 32'(src2_ready);
            default: obs = 32'(busy_count);
         endcase
         check_eq(e.tag, obs, e.exp);
      end
      model_update();
      @(posedge clk); #1;
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      m_busy = '0;
      for (int c = 0; c < NC; c++) m_ck[c] = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // TP1: reset state, alloc not accepted
      alloc_prn[0 +: PW] = 6'd5; alloc_valid[0] = 1'b1; src1_prn[1*PW +: PW] = 6'd5;
      push("tp1_rst_cnt", SEL_CNT, 32'd0);
      push("tp1_r1", SEL_R1, 32'hF);
      run_cycle("tp1a");
      push("tp1_cnt", SEL_CNT, 32'd0);
      run_cycle("tp1b");

      // TP2: full group allocation with intra-group lookups
      alloc(0, 10); alloc(1, 11); alloc(2, 12); alloc(3, 13);
      src1_prn[3*PW +: PW] = 6'd10; src2_prn[2*PW +: PW] = 6'd13;
      push("tp2_r1", SEL_R1, 32'h7);
      push("tp2_r2", SEL_R2, 32'hF);
      run_cycle("tp2a");
      for (int k = 0; k < MW; k++) begin
         src1_prn[k*PW +: PW] = PW'(10 + k); src2_prn[k*PW +: PW] = PW'(10 + k);
      end
      push("tp2_cnt", SEL_CNT, 32'd4);
      push("tp2_busy_r1", SEL_R1, 32'h0);
      push("tp2_busy_r2", SEL_R2, 32'h0);
      run_cycle("tp2b");

      // TP3: writeback forwarding and wb-beats-alloc
      alloc(0, 20);
      run_cycle("tp3a");
      wb(6, 20); src1_prn[0 +: PW] = 6'd20; alloc(1, 21); wb(5, 21);
      push("tp3_fwd_r1", SEL_R1, 32'hF);
      push("tp3_cnt5", SEL_CNT, 32'd5);
      run_cycle("tp3b");
      src1_prn[0 +: PW] = 6'd20; src1_prn[1*PW +: PW] = 6'd21; src2_prn[0 +: PW] = 6'd10;
      push("tp3_clr_r1", SEL_R1, 32'hF);
      push("tp3_r2", SEL_R2, 32'hE);
      push("tp3_cnt4", SEL_CNT, 32'd4);
      run_cycle("tp3c");

      pipe_flush = 1'b1;
      run_cycle("flush1");
      push("flush1_cnt", SEL_CNT, 32'd0);

      // TP4: partial-group save then restore
      alloc(0, 30); alloc(1, 31); alloc(2, 32);
      ckpt_save = 1'b1; ckpt_save_id = 2'd1; ckpt_save_slot = 2'd1;
      run_cycle("tp4a");
      alloc(0, 40);
      push("tp4_cnt3", SEL_CNT, 32'd3);
      run_cycle("tp4b");
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
      run_cycle("tp4c");
      src1_prn = {6'd40, 6'd32, 6'd31, 6'd30};
      push("tp4_r1", SEL_R1, 32'hC);
      push("tp4_cnt2", SEL_CNT, 32'd2);
      run_cycle("tp4d");

      // TP5: checkpoint tracks writebacks; restore drops a same-cycle save
      alloc(0, 50); ckpt_save = 1'b1; ckpt_save_id = 2'd2; ckpt_save_slot = 2'd0;
      run_cycle("tp5a");
      wb(0, 50);
      run_cycle("tp5b");
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; alloc(0, 60);
      ckpt_save = 1'b1; ckpt_save_id = 2'd3; ckpt_save_slot = 2'd3;
      run_cycle("tp5c");
      src1_prn[0 +: PW] = 6'd50;
      push("tp5_r1", SEL_R1, 32'hF);
      push("tp5_cnt2", SEL_CNT, 32'd2);
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd3;
      run_cycle("tp5d");
      push("tp5_ck3_cnt", SEL_CNT, 32'd0);
      run_cycle("tp5e");

      // TP6: PRN 0 never busy; flush clears checkpoints
      alloc(0, 0); src1_prn[0 +: PW] = 6'd0; src1_prn[1*PW +: PW] = 6'd0;
      push("tp6_z_r1", SEL_R1, 32'hF);
      run_cycle("tp6a");
      alloc(0, 1); alloc(1, 2); alloc(2, 3); alloc(3, 4);
      push("tp6_z_cnt", SEL_CNT, 32'd0);
      run_cycle("tp6b");
      alloc(0, 5); alloc(1, 6); alloc(2, 7);
      ckpt_save = 1'b1; ckpt_save_id = 2'd0; ckpt_save_slot = 2'd3;
      run_cycle("tp6c");
      pipe_flush = 1'b1;
      push("tp6_cnt7", SEL_CNT, 32'd7);
      run_cycle("tp6d");
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
      push("tp6_flush_cnt", SEL_CNT, 32'd0);
      run_cycle("tp6e");
      push("tp6_rest_cnt", SEL_CNT, 32'd0);
      run_cycle("tp6f");

      // Random phase over a small PRN range to force collisions
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < MW; i++) begin
            alloc_prn[i*PW +: PW] = PW'($urandom_range(0, 15));
            alloc_valid[i] = 1'($urandom_range(0, 1));
            alloc_ready[i] = ($urandom_range(0, 3) != 0);
            src1_prn[i*PW +: PW] = PW'($urandom_range(0, 15));
            src2_prn[i*PW +: PW] = PW'($urandom_range(0, 15));
         end
         for (int j = 0; j < IW; j++) begin
            wb_prn[j*PW +: PW] = PW'($urandom_range(0, 15));
            wb_valid[j] = ($urandom_range(0, 3) == 0);
         end
         ckpt_save = ($urandom_range(0, 3) == 0);
         ckpt_save_id = CW'($urandom_range(0, 3));
         ckpt_save_slot = 2'($urandom_range(0, 3));
         ckpt_restore = ($urandom_range(0, 7) == 0);
         ckpt_restore_id = CW'($urandom_range(0, 3));
         pipe_flush = ($urandom_range(0, 59) == 0);
         run_cycle("rnd");
      end

      // Asynchronous reset mid-cycle
      for (int k = 0; k < MW; k++) alloc(k, 40 + k);
      run_cycle("pre_rst");
      src1_prn = {6'd43, 6'd42, 6'd41, 6'd40};
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_cnt", 32'(busy_count), 32'd0);
      check_eq("async_rst_r1", 32'(src1_ready), 32'hF);
      m_busy = '0;
      for (int c = 0; c < NC; c++) m_ck[c] = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      run_cycle("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
